// File: rtl/uart_pkg.sv
// Shared state encoding, default sizing and helpers for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } sched_state_e;

  localparam int UART_DATA_W      = 9;
  localparam int UART_ACK_TIMEOUT = 64;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr wins,
// and the search wraps from the last requester back to zero.
module rr_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        any_valid   = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ requesters: round-robin acceptance,
// a single start pulse per frame, and a start-acknowledge watchdog.
module uart_tx_scheduler import uart_pkg::*; #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int ACK_TIMEOUT = UART_ACK_TIMEOUT,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      grant_valid,
  output logic                      err_timeout,
  output logic [7:0]                err_count
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      cnt_q         <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      cnt_q         <= cnt_d;
      err_count_q   <= err_count_d;
    end
  end

  // Acceptance is gated by rst_n so req_ready stays low while reset is held.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    cnt_d         = cnt_q;
    err_count_d   = err_count_q;
    req_ready     = '0;
    tx_start      = 1'b0;
    err_timeout   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any && rst_n) begin
          req_ready     = arb_grant;
          grant_id_d    = arb_idx;
          grant_valid_d = 1'b1;
          rr_ptr_d      = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d       = ST_START;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
              tx_data_d = req_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end

      ST_START: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = ST_WAIT_BUSY;
      end

      // tx_busy is only honoured from here on; a busy seen during START is ignored.
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          err_timeout   = 1'b1;
          err_count_d   = sat_inc8(err_count_q);
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single frame, round-robin order, timeouts,
// asynchronous reset mid-frame and requester drop-out.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 9;
  localparam int ACK_TIMEOUT = 64;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [1:0]                grant_id;
  logic                      grant_valid;
  logic                      err_timeout;
  logic [7:0]                err_count;

  logic xmitEnable;
  logic manualBusy;
  logic modelBusy;
  int   since;
  int   checkCount   = 0;
  int   failCount    = 0;
  int   onehotErrors = 0;

  assign tx_busy = xmitEnable ? modelBusy : manualBusy;

  uart_tx_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .err_timeout (err_timeout),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter stand-in: busy for three cycles starting one cycle after tx_start.
  initial begin
    modelBusy = 1'b0;
    since     = 1000;
    forever begin
      @(negedge clk);
      if (tx_start) since = 0;
      @(posedge clk);
      #1;
      if (since < 1000) since = since + 1;
      modelBusy = (since >= 1 && since <= 3);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic busy);
    @(posedge clk);
    #1;
    req_valid  = valid;
    manualBusy = busy;
    @(negedge clk);
    if (!$onehot0(req_ready)) onehotErrors++;
  endtask

  task automatic waitStart(input logic [NUM_REQ-1:0] valid, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(valid, 1'b0);
      if (tx_start) found = 1'b1;
    end
  endtask

  task automatic doReset();
    rst_n      = 1'b0;
    req_valid  = '0;
    manualBusy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int   gvCycles;
    int   startPulses;
    int   readyPulses;
    int   timeoutAt;
    int   pulses;
    logic dataStable;
    logic found;

    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    manualBusy = 1'b0;
    xmitEnable = 1'b0;
    req_data   = {9'h033, 9'h1A5, 9'h022, 9'h011};

    #12;
    checkOutput("reset_req_ready", 32'(req_ready), 0);
    checkOutput("reset_tx_start", 32'(tx_start), 0);
    checkOutput("reset_tx_data", 32'(tx_data), 0);
    checkOutput("reset_grant_id", 32'(grant_id), 0);
    checkOutput("reset_grant_valid", 32'(grant_valid), 0);
    checkOutput("reset_err_timeout", 32'(err_timeout), 0);
    checkOutput("reset_err_count", 32'(err_count), 0);

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("idle_req_ready", 32'(req_ready), 0);
    checkOutput("idle_grant_valid", 32'(grant_valid), 0);

    // Single request from requester 2; busy rises 3 cycles after start and lasts 20.
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_ready", 32'(req_ready), 4'b0100);
    gvCycles    = 0;
    startPulses = 0;
    readyPulses = 0;
    dataStable  = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      applyStimulus(4'b1011, (k >= 3 && k < 23));
      if (grant_valid) gvCycles++;
      if (tx_start) startPulses++;
      if (req_ready != '0) readyPulses++;
      if (grant_valid && tx_data !== 9'h1A5) dataStable = 1'b0;
      if (k == 0) begin
        checkOutput("single_tx_start", 32'(tx_start), 1);
        checkOutput("single_tx_data", 32'(tx_data), 32'h1A5);
        checkOutput("single_grant_id", 32'(grant_id), 2);
      end
    end
    applyStimulus('0, 1'b0);
    checkOutput("single_gv_cycles", 32'(gvCycles), 24);
    checkOutput("single_start_pulses", 32'(startPulses), 1);
    checkOutput("single_ready_while_busy", 32'(readyPulses), 0);
    checkOutput("single_data_stable", 32'(dataStable), 1);
    checkOutput("single_gv_end", 32'(grant_valid), 0);

    // Timeout: pointer is at 3, so requester 0 wins via wrap; busy during START is ignored.
    applyStimulus(4'b0001, 1'b0);
    checkOutput("to_ready_wrap", 32'(req_ready), 4'b0001);
    timeoutAt = -1;
    for (int k = 0; k <= 65; k++) begin
      applyStimulus(4'b0001, (k == 0));
      if (err_timeout && timeoutAt < 0) timeoutAt = k;
      if (k == 64) checkOutput("to_gv_at_pulse", 32'(grant_valid), 1);
      if (k == 65) begin
        checkOutput("to_pulse_width", 32'(err_timeout), 0);
        checkOutput("to_err_count_1", 32'(err_count), 1);
        checkOutput("to_gv_cleared", 32'(grant_valid), 0);
        checkOutput("to_back_idle", 32'(req_ready), 4'b0001);
      end
    end
    checkOutput("to_latency", 32'(timeoutAt), 64);

    pulses = 1;
    for (int c = 0; c < 300 * 70 && pulses < 300; c++) begin
      applyStimulus(4'b0001, 1'b0);
      if (err_timeout) pulses++;
    end
    checkOutput("to_pulse_total", 32'(pulses), 300);
    applyStimulus('0, 1'b0);
    checkOutput("to_err_count_sat", 32'(err_count), 255);

    // Asynchronous reset while in WAIT_DONE; pointer currently at 1.
    xmitEnable = 1'b1;
    waitStart(4'b1111, found);
    checkOutput("ar_found", 32'(found), 1);
    checkOutput("ar_grant_id", 32'(grant_id), 1);
    applyStimulus(4'b1111, 1'b0);
    applyStimulus(4'b1111, 1'b0);
    checkOutput("ar_gv_in_done", 32'(grant_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_req_ready", 32'(req_ready), 0);
    checkOutput("ar_tx_start", 32'(tx_start), 0);
    checkOutput("ar_tx_data", 32'(tx_data), 0);
    checkOutput("ar_grant_id_0", 32'(grant_id), 0);
    checkOutput("ar_grant_valid", 32'(grant_valid), 0);
    checkOutput("ar_err_timeout", 32'(err_timeout), 0);
    checkOutput("ar_err_count", 32'(err_count), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    startPulses = 0;
    gvCycles    = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus('0, 1'b0);
      if (tx_start) startPulses++;
      if (grant_valid) gvCycles++;
    end
    checkOutput("ar_no_restart", 32'(startPulses), 0);
    checkOutput("ar_no_grant", 32'(gvCycles), 0);

    // All four requesting continuously after reset: order 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      waitStart(4'b1111, found);
      checkOutput($sformatf("rr_found_%0d", n), 32'(found), 1);
      checkOutput($sformatf("rr_grant_%0d", n), 32'(grant_id), n % 4);
    end
    repeat (8) applyStimulus('0, 1'b0);

    // Requester 1 drops while 0 is granted: 3 wins next, then pointer wraps to 0.
    doReset();
    applyStimulus(4'b1011, 1'b0);
    checkOutput("drop_ready_0", 32'(req_ready), 4'b0001);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("drop_grant_0", 32'(grant_id), 0);
    waitStart(4'b1000, found);
    checkOutput("drop_found_3", 32'(found), 1);
    checkOutput("drop_grant_3", 32'(grant_id), 3);
    waitStart(4'b0011, found);
    checkOutput("drop_found_wrap", 32'(found), 1);
    checkOutput("drop_grant_wrap", 32'(grant_id), 0);
    repeat (8) applyStimulus('0, 1'b0);

    checkOutput("ready_onehot", 32'(onehotErrors), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 9: frame payload width handed to the transmitter (data plus parity slot).
REQ-003 Parameter ACK_TIMEOUT, default 64: cycles allowed between tx_start and tx_busy rising.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester frame pending.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-010 tx_data  output  DATA_W  latched payload; stable from tx_start until return to IDLE.
REQ-011 tx_busy  input  1  transmitter frame in progress.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-013 grant_valid  output  1  high from acceptance until the frame completes or times out.
REQ-014 err_timeout  output  1  one-cycle pulse on a start-acknowledge timeout.
REQ-015 err_count  output  8  saturating count of timeouts.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE: when any req_valid is high, the scheduler SHALL select winner g round-robin, starting the search at rr_ptr, and assert req_ready[g] for exactly that cycle.
REQ-018 In the same IDLE cycle, the scheduler SHALL latch tx_data and grant_id, set grant_valid, set rr_ptr to (g+1) mod NUM_REQ, and go to START.
REQ-019 START: tx_start SHALL be 1 for exactly this one cycle; the timeout counter SHALL clear; next state SHALL be WAIT_BUSY.
REQ-020 WAIT_BUSY: tx_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-021 WAIT_BUSY: otherwise the counter SHALL increment; on reaching ACK_TIMEOUT-1 without tx_busy, the scheduler SHALL pulse err_timeout, increment err_count (saturating at 255), clear grant_valid and go to IDLE.
REQ-022 WAIT_DONE: tx_busy=0 SHALL clear grant_valid and return the FSM to IDLE; a new grant SHALL be possible on the following cycle at the earliest.
REQ-023 req_ready SHALL be all-zero in every state other than IDLE, and SHALL never have more than one bit set.
REQ-024 A requester dropping req_valid while not granted SHALL be skipped without penalty; the rr_ptr search SHALL wrap from NUM_REQ-1 to 0.
REQ-025 tx_busy rising on the same cycle as tx_start SHALL be ignored; only tx_busy sampled in WAIT_BUSY counts.
REQ-026 If all req_valid are low in IDLE, all outputs SHALL hold their idle values and rr_ptr SHALL not change.

Reset
REQ-027 While rst_n is low, the block SHALL be in state IDLE with rr_ptr=0, req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_valid=0, err_timeout=0 and err_count=0, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abandon the grant without a completion or error indication; tx_start SHALL not be reissued after release.

Structure
REQ-029 The state encoding, the default DATA_W and the default ACK_TIMEOUT SHALL reside in the shared package uart_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and pointer; outputs: one-hot grant, index, any-valid) that is purely combinational.

Verification
REQ-031 Single request: req_valid=4'b0100 with data 9'h1A5, tx_busy rising 3 cycles after tx_start and falling 20 cycles later -> req_ready=4'b0100 for 1 cycle, tx_data=9'h1A5, grant_id=2, grant_valid high for 24 cycles.
REQ-032 All four requesting continuously from reset -> grant order 0,1,2,3,0 with no requester granted twice before the others.
REQ-033 tx_busy held 0 -> err_timeout pulses 64 cycles after tx_start, err_count=1, FSM back in IDLE; 300 repeated timeouts -> err_count=255.
REQ-034 rst_n asserted in WAIT_DONE -> all outputs are zero immediately (asynchronously); after release, grant order restarts at requester 0.
REQ-035 Requester 1 drops req_valid while requester 0 is granted, with requesters 1 and 3 requesting -> next grant_id=3, and the pointer wraps to 0.
